branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised successor to the single-cycle branch comparator: resolves MIPS conditional branches (BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL) in one registered pipeline stage with a valid/ready handshake. It also computes the branch target and link address. It keeps a table of 2-bit saturating counters that is updated on every resolved branch, and the fetch stage reads that table through a combinational query port. It sits between decode (producer) and the PC-select/flush logic (consumer).

## Interface
- `W`, default 32: datapath width for operands, PC, target and link (≥ 18).
- `BHT_DEPTH`, default 64: number of predictor counters; power of two, ≥ 2. The index is `pc[log2(BHT_DEPTH)+1:2]`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: request accepted this cycle when high together with `in_valid`.
- `in_pc`  in  W: PC of the branch.
- `in_a`, `in_b`  in  W each: rs and rt operand values.
- `in_op`  in  6: instruction opcode.
- `in_rt`  in  5: REGIMM sub-code (instruction rt field).
- `in_imm`  in  16: branch offset.
- `in_pred_taken`  in  1: prediction that fetch used for this branch.
- `flush`  in  1: discard the held result and the current request.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_is_branch`  out  1: opcode was a recognised branch.
- `out_taken`  out  1: branch condition true.
- `out_target`  out  W: `pc + 4 + (sext(imm) << 2)`, modulo 2^W.
- `out_link`  out  W: `pc + 8`, modulo 2^W.
- `out_link_en`  out  1: BLTZAL or BGEZAL (asserted whether taken or not).
- `out_mispredict`  out  1: `out_is_branch & (out_taken != pred_taken)`.
- `q_pc`  in  W: fetch-stage query PC.
- `q_taken`  out  1: MSB of the counter at `q_pc`'s index (combinational).
- `stat_branches`, `stat_mispredicts`  out  32 each: statistics counters (see Configuration).

## Operation
- Conditions:
  - Opcodes: BEQ 000100 (a==b), BNE 000101 (a!=b), BLEZ 000110 (signed a≤0), BGTZ 000111 (signed a>0).
  - REGIMM 000001 with in_rt: BLTZ 00000 and BLTZAL 10000 (signed a<0); BGEZ 00001 and BGEZAL 10001 (signed a≥0).
  - Any other op or in_rt: out_is_branch=0, out_taken=0, out_link_en=0, out_mispredict=0.
  - All comparisons are signed, on the full W bits.
- Output register:
  - `in_ready = !out_valid | out_ready`.
  - On `in_valid & in_ready & !flush`, all out_* fields are computed and registered and out_valid is set.
  - When `out_valid & out_ready` occurs with no new capture, out_valid clears.
  - out_* fields hold stable while `out_valid & !out_ready`.
- flush:
  - Next cycle out_valid=0.
  - The request in that cycle is not captured.
  - The predictor is not updated by the flushed result.
- Predictor:
  - Updated when `out_valid & out_ready & out_is_branch & !flush`. Index comes from the registered pc.
  - Update rule: increment, saturating at 3, if taken; decrement, saturating at 0, if not taken.
  - If an update and a query hit the same index in the same cycle, q_taken returns the pre-update value.

## Timing
- Latency: one cycle from accepted request to out_valid.
- Throughput: one result per cycle while out_ready=1.
- Reset (async, immediate):
  - out_valid=0, and all other out_* fields are 0.
  - Every counter is set to 2'b01 (weakly not-taken), so q_taken=0.
  - stat_* counters are 0.
  - A reset during a held result drops that result, with no predictor update.
- q_taken is purely combinational from q_pc and the table state; it never stalls.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and nothing is captured.

## Configuration
- `BRANCH_RESOLVE_STATS_EN` defined:
  - stat_branches increments on each predictor update event.
  - stat_mispredicts increments on those events when out_mispredict=1.
  - Both counters wrap at 2^32.
- Not defined: stat_* are tied to 0 and no counter logic is synthesised. The port list is unchanged.

## Test plan
- BEQ, a=b=0x0000_0005, pc=0x0040_0000, imm=0xFFFF, out_ready=1 → one cycle later: out_taken=1, target=0x0040_0000, link=0x0040_0008, is_branch=1.
- BGTZ with a=0x8000_0000, then BGEZAL with a=0, with pred_taken=1 both times → first result taken=0, mispredict=1; second result taken=1, link_en=1, mispredict=0.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 throughout, out_* stable; after release, the next request is captured in the release cycle.
- Resolve four taken branches at pc=0x100 with BHT_DEPTH=64 → q_pc=0x100 gives q_taken=1 after the first update; counter reaches 3; one not-taken branch keeps q_taken=1. q_pc=0x200 aliases to the same index (index 0), so it also gives q_taken=1.
- Assert flush with out_valid=1 and in_valid=1 → next cycle out_valid=0, no predictor change; with the macro defined, stat counters are unchanged.
- Assert rst mid-stream, then op=6'b001000 (ADDI) → after reset all outputs are 0 and q_taken=0; the ADDI result has is_branch=0, taken=0, mispredict=0, and no predictor update.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-stage registered MIPS branch resolver with valid/ready handshake and a 2-bit BHT.
// Define BRANCH_RESOLVE_STATS_EN to build the branch/mispredict statistics counters.
module branch_resolve_unit #(
    parameter int unsigned W         = 32,
    parameter int unsigned BHT_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [5:0]   in_op,
    input  logic [4:0]   in_rt,
    input  logic [15:0]  in_imm,
    input  logic         in_pred_taken,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_is_branch,
    output logic         out_taken,
    output logic [W-1:0] out_target,
    output logic [W-1:0] out_link,
    output logic         out_link_en,
    output logic         out_mispredict,
    input  logic [W-1:0] q_pc,
    output logic         q_taken,
    output logic [31:0]  stat_branches,
    output logic [31:0]  stat_mispredicts
);

    localparam int unsigned IW = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [W-1:0] PC_PLUS4 = W'(4);
    localparam logic [W-1:0] PC_PLUS8 = W'(8);

    // Output register state
    logic          out_valid_q, out_valid_d;
    logic          is_branch_q, is_branch_d;
    logic          taken_q, taken_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  link_q, link_d;
    logic          link_en_q, link_en_d;
    logic          mispred_q, mispred_d;
    logic [IW-1:0] idx_q;

    // Predictor table
    logic [1:0]    bht_q [BHT_DEPTH];
    logic [1:0]    cnt_cur, cnt_d;

    logic          capture;
    logic          bht_upd;
    logic          a_neg;
    logic          a_zero;
    logic          unused_q_pc;

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign bht_upd  = out_valid_q && out_ready && is_branch_q && !flush;

    assign a_neg  = in_a[W-1];
    assign a_zero = (in_a == '0);

    always_comb begin
        is_branch_d = 1'b0;
        taken_d     = 1'b0;
        link_en_d   = 1'b0;
        case (in_op)
            OP_BEQ: begin
                is_branch_d = 1'b1;
                taken_d     = (in_a == in_b);
            end
            OP_BNE: begin
                is_branch_d = 1'b1;
                taken_d     = (in_a != in_b);
            end
            OP_BLEZ: begin
                is_branch_d = 1'b1;
                taken_d     = a_neg || a_zero;
            end
            OP_BGTZ: begin
                is_branch_d = 1'b1;
                taken_d     = !a_neg && !a_zero;
            end
            OP_REGIMM: begin
                case (in_rt)
                    RT_BLTZ, RT_BLTZAL: begin
                        is_branch_d = 1'b1;
                        taken_d     = a_neg;
                        link_en_d   = in_rt[4];
                    end
                    RT_BGEZ, RT_BGEZAL: begin
                        is_branch_d = 1'b1;
                        taken_d     = !a_neg;
                        link_en_d   = in_rt[4];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mispred_d = is_branch_d && (taken_d != in_pred_taken);
    assign target_d  = in_pc + PC_PLUS4 + {{(W-18){in_imm[15]}}, in_imm, 2'b00};
    assign link_d    = in_pc + PC_PLUS8;

    // Flush wins over both a new capture and a consumer handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            is_branch_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            link_q      <= '0;
            link_en_q   <= 1'b0;
            mispred_q   <= 1'b0;
            idx_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (capture) begin
                is_branch_q <= is_branch_d;
                taken_q     <= taken_d;
                target_q    <= target_d;
                link_q      <= link_d;
                link_en_q   <= link_en_d;
                mispred_q   <= mispred_d;
                idx_q       <= in_pc[IW+1:2];
            end
        end
    end

    assign cnt_cur = bht_q[idx_q];

    always_comb begin
        cnt_d = cnt_cur;
        if (taken_q) begin
            if (cnt_cur != 2'b11) begin
                cnt_d = cnt_cur + 2'b01;
            end
        end else begin
            if (cnt_cur != 2'b00) begin
                cnt_d = cnt_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            bht_q[idx_q] <= cnt_d;
        end
    end

    // Table read sees the registered state, so a same-cycle update is not forwarded.
    assign q_taken     = bht_q[q_pc[IW+1:2]][1];
    assign unused_q_pc = ^{q_pc[W-1:IW+2], q_pc[1:0]};

    assign out_valid      = out_valid_q;
    assign out_is_branch  = is_branch_q;
    assign out_taken      = taken_q;
    assign out_target     = target_q;
    assign out_link       = link_q;
    assign out_link_en    = link_en_q;
    assign out_mispredict = mispred_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (bht_upd) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (mispred_q) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected results plus a reference BHT model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rt = '0;
    logic [15:0] in_imm = '0;
    logic        in_pred_taken = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_is_branch;
    logic        out_taken;
    logic [31:0] out_target;
    logic [31:0] out_link;
    logic        out_link_en;
    logic        out_mispredict;
    logic [31:0] q_pc = 32'h100;
    logic        q_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_resolve_unit #(.W(32), .BHT_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_rt(in_rt), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_branch(out_is_branch), .out_taken(out_taken),
        .out_target(out_target), .out_link(out_link),
        .out_link_en(out_link_en), .out_mispredict(out_mispredict),
        .q_pc(q_pc), .q_taken(q_taken),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        tk;
        logic        le;
        logic        mp;
        logic [31:0] tgt;
        logic [31:0] lnk;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  bht_m [64];
    logic        exp_valid = 1'b0;
    int unsigned n_br = 0;
    int unsigned n_mp = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [4:0] rt,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [15:0] imm,
                                   input logic pred);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] off;
        sa   = a;
        off  = {{16{imm[15]}}, imm};
        e.br = 1'b0;
        e.tk = 1'b0;
        e.le = 1'b0;
        if (op == 6'd4) begin
            e.br = 1'b1; e.tk = (a == b);
        end else if (op == 6'd5) begin
            e.br = 1'b1; e.tk = (a != b);
        end else if (op == 6'd6) begin
            e.br = 1'b1; e.tk = (sa <= 0);
        end else if (op == 6'd7) begin
            e.br = 1'b1; e.tk = (sa > 0);
        end else if (op == 6'd1 && (rt == 5'd0 || rt == 5'd16)) begin
            e.br = 1'b1; e.tk = (sa < 0); e.le = (rt == 5'd16);
        end else if (op == 6'd1 && (rt == 5'd1 || rt == 5'd17)) begin
            e.br = 1'b1; e.tk = (sa >= 0); e.le = (rt == 5'd17);
        end
        e.mp  = e.br && (e.tk != pred);
        e.tgt = pc + 32'd4 + 32'(off * 4);
        e.lnk = pc + 32'd8;
        e.pc  = pc;
        return e;
    endfunction

    // One negedge step of the reference model: handshake, scoreboard, predictor, statistics.
    task automatic mon_step();
        exp_t e;
        logic cap;
        if (rst) begin
            sb.delete();
            exp_valid = 1'b0;
            n_br = 0;
            n_mp = 0;
            for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
            return;
        end
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, !exp_valid || out_ready);
        check("q_taken", q_taken, bht_m[q_pc[7:2]][1]);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_branches", stat_branches, n_br);
        check("stat_mispredicts", stat_mispredicts, n_mp);
`else
        check("stat_branches", stat_branches, 32'd0);
        check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        if (exp_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_pending", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("is_branch", out_is_branch, e.br);
                check("taken", out_taken, e.tk);
                check("target", out_target, e.tgt);
                check("link", out_link, e.lnk);
                check("link_en", out_link_en, e.le);
                check("mispredict", out_mispredict, e.mp);
                if (e.br && !flush) begin
                    if (e.tk && bht_m[e.pc[7:2]] != 2'd3) bht_m[e.pc[7:2]] = bht_m[e.pc[7:2]] + 2'd1;
                    if (!e.tk && bht_m[e.pc[7:2]] != 2'd0) bht_m[e.pc[7:2]] = bht_m[e.pc[7:2]] - 2'd1;
                    n_br++;
                    if (e.mp) n_mp++;
                end
            end
        end else if (exp_valid && flush && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        cap = in_valid && (!exp_valid || out_ready) && !flush;
        if (cap) sb.push_back(model(in_op, in_rt, in_a, in_b, in_pc, in_imm, in_pred_taken));
        if (flush) exp_valid = 1'b0;
        else if (cap) exp_valid = 1'b1;
        else if (out_ready) exp_valid = 1'b0;
    endtask

    task automatic set_req(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                           input logic pred);
        in_op = op; in_rt = rt; in_a = a; in_b = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pred;
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic drive(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [15:0] imm,
                         input logic pred);
        logic ok;
        ok = 1'b0;
        set_req(op, rt, a, b, pc, imm, pred);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        if (!ok) check("drive_timeout", ok, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0]  t_op  [10] = '{6'd5, 6'd6, 6'd6, 6'd1, 6'd1, 6'd1, 6'd1, 6'd0, 6'd5, 6'd7};
    logic [4:0]  t_rt  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0};
    logic [31:0] t_a   [10] = '{32'd7, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB,
                                32'hFFFF_FFFF, 32'd3, 32'd1, 32'h7FFF_FFFF};
    logic [31:0] t_b   [10] = '{32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd2, 32'd0};
    logic [31:0] t_pc  [10] = '{32'h204, 32'h208, 32'h20C, 32'h210, 32'h214, 32'h218,
                                32'h21C, 32'h220, 32'hFFFF_FFF8, 32'h0000_0010};
    logic [15:0] t_imm [10] = '{16'h0010, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE, 16'h0003,
                                16'h0004, 16'h0005, 16'h0001, 16'hFFF8};

    logic [127:0] snap;

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset values, visible before any clock edge
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_fields", {out_is_branch, out_taken, out_link_en, out_mispredict, out_target, out_link}, '0);
        check("rst_q_taken", q_taken, 1'b0);
        check("rst_stats", {stat_branches, stat_mispredicts}, '0);
        idle(2);
        rst = 1'b0;

        // Predictor training at pc 0x100 (index 0)
        drive(6'd4, 5'd0, 32'd1, 32'd1, 32'h100, 16'h0001, 1'b0);
        idle(1);
        check("bht_first_update", q_taken, 1'b1);
        for (int i = 0; i < 3; i++) drive(6'd4, 5'd0, 32'd1, 32'd1, 32'h100, 16'h0001, 1'b1);
        drive(6'd4, 5'd0, 32'd1, 32'd2, 32'h100, 16'h0001, 1'b1);
        idle(2);
        check("bht_saturated_hold", q_taken, 1'b1);
        q_pc = 32'h200;
        #1;
        check("bht_alias", q_taken, 1'b1);
        q_pc = 32'h100;

        // BEQ with negative offset
        drive(6'd4, 5'd0, 32'h5, 32'h5, 32'h0040_0000, 16'hFFFF, 1'b1);
        check("beq_taken", out_taken, 1'b1);
        check("beq_target", out_target, 32'h0040_0000);
        check("beq_link", out_link, 32'h0040_0008);
        check("beq_is_branch", out_is_branch, 1'b1);

        // BGTZ on most-negative value, then BGEZAL on zero
        drive(6'd7, 5'd0, 32'h8000_0000, 32'd0, 32'h1000, 16'h0004, 1'b1);
        check("bgtz_taken", out_taken, 1'b0);
        check("bgtz_mispredict", out_mispredict, 1'b1);
        drive(6'd1, 5'd17, 32'd0, 32'd0, 32'h1004, 16'h0004, 1'b1);
        check("bgezal_taken", out_taken, 1'b1);
        check("bgezal_link_en", out_link_en, 1'b1);
        check("bgezal_mispredict", out_mispredict, 1'b0);

        // Pattern table, back to back
        for (int i = 0; i < 10; i++)
            drive(t_op[i], t_rt[i], t_a[i], t_b[i], t_pc[i], t_imm[i], 1'($urandom_range(0, 1)));
        idle(1);

        // Backpressure: held result stays stable, next request lands in the release cycle
        out_ready = 1'b0;
        drive(6'd5, 5'd0, 32'd1, 32'd2, 32'h500, 16'h0020, 1'b0);
        set_req(6'd1, 5'd16, 32'hFFFF_FFF0, 32'd0, 32'h600, 16'h0002, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        snap = {out_is_branch, out_taken, out_link_en, out_mispredict, out_target, out_link};
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_stable", {out_is_branch, out_taken, out_link_en, out_mispredict, out_target, out_link}, snap);
            @(posedge clk);
            #1;
            if (k != 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release_valid", out_valid, 1'b1);
        check("bp_release_target", out_target, 32'h0000_060C);
        idle(1);

        // Flush while the consumer accepts: no capture, no predictor update
        q_pc = 32'h104;
        drive(6'd4, 5'd0, 32'd9, 32'd9, 32'h104, 16'h0001, 1'b0);
        flush = 1'b1;
        set_req(6'd4, 5'd0, 32'd9, 32'd9, 32'h104, 16'h0001, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 1'b0);
        check("flush_no_update", q_taken, 1'b0);

        // Flush while the result is held
        out_ready = 1'b0;
        drive(6'd4, 5'd0, 32'd9, 32'd9, 32'h104, 16'h0001, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_held_valid", out_valid, 1'b0);
        idle(1);
        check("flush_held_no_update", q_taken, 1'b0);
        q_pc = 32'h100;

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        drive(6'd4, 5'd0, 32'd1, 32'd1, 32'h108, 16'h0001, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_fields", {out_is_branch, out_taken, out_link_en, out_mispredict, out_target, out_link}, '0);
        check("arst_q_taken", q_taken, 1'b0);
        check("arst_stats", {stat_branches, stat_mispredicts}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Non-branch opcode after reset
        drive(6'd8, 5'd0, 32'd1, 32'd1, 32'h100, 16'h0001, 1'b1);
        check("addi_is_branch", out_is_branch, 1'b0);
        check("addi_taken", out_taken, 1'b0);
        check("addi_mispredict", out_mispredict, 1'b0);
        idle(1);
        check("addi_no_update", q_taken, 1'b0);

        for (int i = 0; i < 20 && (sb.size() != 0 || exp_valid); i++) @(negedge clk);
        check("drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
